mac_route_table: RTL

MAC_ROUTE_TABLE -- requirements
Module: mac_route_table

---
 rtl/mac_route_table.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/mac_route_table.sv
// Learning MAC table with round-robin learn arbiter, aging sweeps and a lookup port.
// Lookup response is registered (1 cycle) and held under backpressure; learns need no stall.
module mac_route_table #(
   parameter int NPORTS     = 4,
   parameter int MACW       = 48,
   parameter int NTBL       = 8,
   parameter int AGE_PERIOD = 1000000
) (
   input  logic                       i_clk,
   input  logic                       i_reset,
   input  logic [NPORTS-1:0]          S_LEARN_VALID,
   output logic [NPORTS-1:0]          S_LEARN_READY,
   input  logic [NPORTS*MACW-1:0]     S_LEARN_MAC,
   input  logic                       LKUP_VALID,
   output logic                       LKUP_READY,
   input  logic [MACW-1:0]            LKUP_MAC,
   input  logic [$clog2(NPORTS)-1:0]  LKUP_SRCPORT,
   output logic                       RESP_VALID,
   input  logic                       RESP_READY,
   output logic [NPORTS-1:0]          RESP_PORTS
);

   localparam int PW    = $clog2(NPORTS);
   localparam int TW    = $clog2(NTBL);
   localparam int AW    = $clog2(AGE_PERIOD);
   localparam int MCBIT = MACW - 8;

   logic [NTBL-1:0] ent_vld;
   logic [NTBL-1:0] ent_seen;
   logic [MACW-1:0] ent_mac  [NTBL];
   logic [PW-1:0]   ent_port [NTBL];

   logic [PW-1:0]   rr;
   logic [TW-1:0]   rp;
   logic [AW-1:0]   age_cnt;

   logic [PW-1:0]   gnt;
   logic            learn_fire;
   logic [MACW-1:0] learn_mac;
   logic            learn_wr;
   logic            learn_hit;
   logic            free_found;
   logic            replace;
   logic            sweep;
   logic [TW-1:0]   hit_idx;
   logic [TW-1:0]   free_idx;
   logic [TW-1:0]   lk_idx;
   logic [TW-1:0]   tgt;
   logic [NTBL-1:0] learn_hit_vec;
   logic [NTBL-1:0] lkup_hit_vec;
   logic            lkup_fire;
   logic [NPORTS-1:0] flood;
   logic [NPORTS-1:0] resp_nxt;

   // Round-robin: first requester at or after rr, wrapping.
   always_comb begin
      int idx;
      idx           = 0;
      gnt           = '0;
      learn_fire    = 1'b0;
      S_LEARN_READY = '0;
      for (int i = 0; i < NPORTS; i++) begin
         idx = (int'(rr) + i) % NPORTS;
         if (!learn_fire && S_LEARN_VALID[idx]) begin
            learn_fire = 1'b1;
            gnt        = PW'(idx);
         end
      end
      if (learn_fire) S_LEARN_READY[gnt] = 1'b1;
   end

   assign learn_mac = S_LEARN_MAC[int'(gnt)*MACW +: MACW];
   assign learn_wr  = learn_fire && !learn_mac[MCBIT];

   always_comb begin
      for (int e = 0; e < NTBL; e++) begin
         learn_hit_vec[e] = ent_vld[e] && (ent_mac[e] == learn_mac);
         lkup_hit_vec[e]  = ent_vld[e] && (ent_mac[e] == LKUP_MAC);
      end
   end

   // Descending scan so the lowest matching/free index is the one that sticks.
   always_comb begin
      hit_idx  = '0;
      free_idx = '0;
      lk_idx   = '0;
      for (int e = NTBL-1; e >= 0; e--) begin
         if (learn_hit_vec[e]) hit_idx  = TW'(e);
         if (!ent_vld[e])      free_idx = TW'(e);
         if (lkup_hit_vec[e])  lk_idx   = TW'(e);
      end
   end

   assign learn_hit  = |learn_hit_vec;
   assign free_found = ~&ent_vld;
   assign tgt        = learn_hit ? hit_idx : (free_found ? free_idx : rp);
   assign replace    = learn_wr && !learn_hit && !free_found;
   assign sweep      = (age_cnt == AW'(AGE_PERIOD - 1));

   assign LKUP_READY = !RESP_VALID || RESP_READY;
   assign lkup_fire  = LKUP_VALID && LKUP_READY;

   always_comb begin
      flood               = '1;
      flood[LKUP_SRCPORT] = 1'b0;
      resp_nxt            = '0;
      if (LKUP_MAC[MCBIT] || !(|lkup_hit_vec))
         resp_nxt = flood;
      else if (ent_port[lk_idx] != LKUP_SRCPORT)
         resp_nxt[ent_port[lk_idx]] = 1'b1;
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         ent_vld    <= '0;
         ent_seen   <= '0;
         rr         <= '0;
         rp         <= '0;
         age_cnt    <= '0;
         RESP_VALID <= 1'b0;
         RESP_PORTS <= '0;
      end else begin
         age_cnt <= sweep ? '0 : age_cnt + 1'b1;
         if (sweep) begin
            ent_vld  <= ent_vld & ent_seen;
            ent_seen <= '0;
         end
         if (learn_fire)
            rr <= (gnt == PW'(NPORTS - 1)) ? '0 : gnt + 1'b1;
         // Issued after the sweep so a same-cycle learn keeps its entry alive.
         if (learn_wr) begin
            ent_vld[tgt]  <= 1'b1;
            ent_seen[tgt] <= 1'b1;
         end
         if (replace) rp <= rp + 1'b1;
         if (lkup_fire) begin
            RESP_VALID <= 1'b1;
            RESP_PORTS <= resp_nxt;
         end else if (RESP_READY) begin
            RESP_VALID <= 1'b0;
         end
      end
   end

   // Payload needs no reset: it is only observed through a valid entry.
   always_ff @(posedge i_clk) begin
      if (learn_wr) begin
         ent_mac[tgt]  <= learn_mac;
         ent_port[tgt] <= gnt;
      end
   end

endmodule
